// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the program sequencer
// Contents: state_t (IDLE/RUN/DONE), cond_t (branch condition select), DEF_HALT_ADDR.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_ZERO   = 2'b01,
        COND_PARI   = 2'b10,
        COND_SC     = 2'b11
    } cond_t;

    localparam int DEF_HALT_ADDR = 128;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - hardware return-address stack (LIFO)
// Ports: clk, reset (sync active-low), clear (empty the stack), push/push_data,
//        pop, top (most recent entry), full, empty.
// Push when full and pop when empty are ignored; the caller flags the error.
module ret_stack #(
    parameter int D         = 12,
    parameter int STK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(STK_DEPTH);

    logic [D-1:0] mem [STK_DEPTH];
    logic [PW:0]  cnt;
    logic [PW-1:0] top_idx;

    assign top_idx = PW'(cnt - 1'b1);
    assign top     = mem[top_idx];
    assign full    = (cnt == (PW+1)'(STK_DEPTH));
    assign empty   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below cnt.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program counter, run handshake, ALU flag registers and return stack
// Ports: clk, reset (sync active-low); req/stall run control; reljump_en, absjump_en,
//        call_en, ret_en, cond_sel, target, offset PC controls; zero, pari, flag_en,
//        sc_o, sc_clr, sc_en flag inputs; prog_ctr, zeroQ, pariQ, sc_in, busy, done,
//        stk_err outputs.
// Macro SEQ_CALL_STACK_EN: enables the return stack, call/ret and stk_err. When
// undefined, call_en is an unconditional absolute jump, ret_en is a plain PC+1 and
// stk_err is tied low.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int D         = 12,
    parameter int HALT_ADDR = DEF_HALT_ADDR,
    parameter int STK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         reljump_en,
    input  logic         absjump_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [1:0]   cond_sel,
    input  logic [D-1:0] target,
    input  logic [D-1:0] offset,
    input  logic         zero,
    input  logic         pari,
    input  logic         flag_en,
    input  logic         sc_o,
    input  logic         sc_clr,
    input  logic         sc_en,
    output logic [D-1:0] prog_ctr,
    output logic         zeroQ,
    output logic         pariQ,
    output logic         sc_in,
    output logic         busy,
    output logic         done,
    output logic         stk_err
);

    localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

    state_t       state;
    logic         cond;
    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_next;
    logic         advance;
    logic         start;

    assign pc_inc  = prog_ctr + D'(1);
    assign advance = (state == RUN) && !stall && (prog_ctr != HALT_PC);
    assign start   = (state == IDLE) && req;

    always_comb begin
        cond = 1'b1;
        case (cond_t'(cond_sel))
            COND_ALWAYS: cond = 1'b1;
            COND_ZERO:   cond = zeroQ;
            COND_PARI:   cond = pariQ;
            COND_SC:     cond = sc_in;
            default:     cond = 1'b1;
        endcase
    end

`ifdef SEQ_CALL_STACK_EN
    logic [D-1:0] stk_top;
    logic         stk_full;
    logic         stk_empty;
    logic         push_req;
    logic         pop_req;
    logic         err_req;

    always_comb begin
        pc_next  = pc_inc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_req  = 1'b0;
        if (ret_en) begin
            if (stk_empty) begin
                err_req = 1'b1;
            end else begin
                pc_next = stk_top;
                pop_req = 1'b1;
            end
        end else if (call_en) begin
            if (stk_full) begin
                err_req = 1'b1;
            end else begin
                pc_next  = target;
                push_req = 1'b1;
            end
        end else if (absjump_en) begin
            if (cond) pc_next = target;
        end else if (reljump_en) begin
            if (cond) pc_next = prog_ctr + offset;
        end
    end

    ret_stack #(
        .D         (D),
        .STK_DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .push      (advance && push_req),
        .pop       (advance && pop_req),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset || start) begin
            stk_err <= 1'b0;
        end else if (advance && err_req) begin
            stk_err <= 1'b1;
        end
    end
`else
    // Without the stack a return has nowhere to go, so it degrades to PC+1
    // but still outranks call.
    always_comb begin
        pc_next = pc_inc;
        if (ret_en) begin
            pc_next = pc_inc;
        end else if (call_en) begin
            pc_next = target;
        end else if (absjump_en) begin
            if (cond) pc_next = target;
        end else if (reljump_en) begin
            if (cond) pc_next = prog_ctr + offset;
        end
    end

    assign stk_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            prog_ctr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prog_ctr <= '0;
                    if (req) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Halt check ignores stall: reaching HALT_ADDR ends the run.
                    if (prog_ctr == HALT_PC) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!stall) begin
                        prog_ctr <= pc_next;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state    <= IDLE;
                        done     <= 1'b0;
                        prog_ctr <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    prog_ctr <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Flags update in every state, stalled or not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            zeroQ <= 1'b0;
            pariQ <= 1'b0;
            sc_in <= 1'b0;
        end else begin
            if (flag_en) begin
                zeroQ <= zero;
                pariQ <= pari;
            end
            if (sc_clr) begin
                sc_in <= 1'b0;
            end else if (sc_en) begin
                sc_in <= sc_o;
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed self-checking bench for prog_sequencer
module tb_prog_sequencer;

    localparam int D = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic         stall;
    logic         reljump_en;
    logic         absjump_en;
    logic         call_en;
    logic         ret_en;
    logic [1:0]   cond_sel;
    logic [D-1:0] target;
    logic [D-1:0] offset;
    logic         zero;
    logic         pari;
    logic         flag_en;
    logic         sc_o;
    logic         sc_clr;
    logic         sc_en;
    logic [D-1:0] prog_ctr;
    logic         zeroQ;
    logic         pariQ;
    logic         sc_in;
    logic         busy;
    logic         done;
    logic         stk_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_sequencer #(
        .D         (D),
        .HALT_ADDR (128),
        .STK_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .reljump_en (reljump_en),
        .absjump_en (absjump_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .cond_sel   (cond_sel),
        .target     (target),
        .offset     (offset),
        .zero       (zero),
        .pari       (pari),
        .flag_en    (flag_en),
        .sc_o       (sc_o),
        .sc_clr     (sc_clr),
        .sc_en      (sc_en),
        .prog_ctr   (prog_ctr),
        .zeroQ      (zeroQ),
        .pariQ      (pariQ),
        .sc_in      (sc_in),
        .busy       (busy),
        .done       (done),
        .stk_err    (stk_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        call_en    = 1'b0;
        ret_en     = 1'b0;
        cond_sel   = 2'b00;
        stall      = 1'b0;
    endtask

    task automatic jump_abs(input logic [D-1:0] t);
        clear_ctl();
        absjump_en = 1'b1;
        target     = t;
        tick();
        absjump_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; target = '0; offset = '0;
        zero = 1'b0; pari = 1'b0; flag_en = 1'b0; sc_o = 1'b0; sc_clr = 1'b0; sc_en = 1'b0;
        clear_ctl();
        tick();
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stk_err", 32'(stk_err), 0);

        // Run to PC=37 with all flags set, then reset mid-run.
        reset = 1'b1; req = 1'b1;
        tick();
        chk("start_busy", 32'(busy), 1);
        chk("start_pc", 32'(prog_ctr), 0);
        flag_en = 1'b1; zero = 1'b1; pari = 1'b1; sc_en = 1'b1; sc_o = 1'b1;
        repeat (37) tick();
        flag_en = 1'b0; zero = 1'b0; pari = 1'b0; sc_en = 1'b0; sc_o = 1'b0;
        chk("run_pc37", 32'(prog_ctr), 37);
        chk("run_zeroQ", 32'(zeroQ), 1);
        chk("run_sc_in", 32'(sc_in), 1);
        reset = 1'b0;
        tick();
        chk("midrst_pc", 32'(prog_ctr), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_zeroQ", 32'(zeroQ), 0);
        chk("midrst_pariQ", 32'(pariQ), 0);
        chk("midrst_sc_in", 32'(sc_in), 0);

        // Full run to the halt address.
        reset = 1'b1;
        tick();
        chk("run2_busy", 32'(busy), 1);
        chk("run2_pc0", 32'(prog_ctr), 0);
        repeat (128) tick();
        chk("halt_pc", 32'(prog_ctr), 128);
        chk("halt_done_pre", 32'(done), 0);
        tick();
        chk("halt_done", 32'(done), 1);
        chk("halt_busy", 32'(busy), 0);
        tick();
        chk("halt_hold_pc", 32'(prog_ctr), 128);
        chk("halt_hold_done", 32'(done), 1);
        req = 1'b0;
        tick();
        chk("idle_done", 32'(done), 0);
        chk("idle_pc", 32'(prog_ctr), 0);

        // Conditional relative jump.
        req = 1'b1;
        tick();
        jump_abs(12'd20);
        chk("abs_pc20", 32'(prog_ctr), 20);
        stall = 1'b1; flag_en = 1'b1; zero = 1'b1;
        tick();
        stall = 1'b0; flag_en = 1'b0;
        chk("stall_flag_pc", 32'(prog_ctr), 20);
        chk("zeroQ_set", 32'(zeroQ), 1);
        reljump_en = 1'b1; cond_sel = 2'b01; offset = 12'hFFB;
        tick();
        reljump_en = 1'b0;
        chk("rel_taken", 32'(prog_ctr), 15);
        jump_abs(12'd20);
        stall = 1'b1; flag_en = 1'b1; zero = 1'b0;
        tick();
        stall = 1'b0; flag_en = 1'b0;
        chk("zeroQ_clr", 32'(zeroQ), 0);
        reljump_en = 1'b1; cond_sel = 2'b01;
        tick();
        reljump_en = 1'b0;
        chk("rel_untaken", 32'(prog_ctr), 21);

        // Stall blocks jumps; sc_clr beats sc_en.
        jump_abs(12'd8);
        chk("abs_pc8", 32'(prog_ctr), 8);
        stall = 1'b1; absjump_en = 1'b1; target = 12'd50;
        sc_en = 1'b1; sc_o = 1'b1;
        tick();
        chk("stall_sc_load", 32'(sc_in), 1);
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0; sc_en = 1'b0; sc_o = 1'b0;
        chk("stall_pc", 32'(prog_ctr), 8);
        chk("sc_clr_wins", 32'(sc_in), 0);
        clear_ctl();

        // pariQ and sc_in as branch conditions.
        stall = 1'b1; flag_en = 1'b1; pari = 1'b1;
        tick();
        stall = 1'b0; flag_en = 1'b0; pari = 1'b0;
        absjump_en = 1'b1; cond_sel = 2'b10; target = 12'd40;
        tick();
        chk("abs_pari_taken", 32'(prog_ctr), 40);
        cond_sel = 2'b11; target = 12'd60;
        tick();
        chk("abs_sc_untaken", 32'(prog_ctr), 41);
        clear_ctl();

`ifdef SEQ_CALL_STACK_EN
        jump_abs(12'd10);
        call_en = 1'b1; target = 12'd200;
        tick();
        call_en = 1'b0;
        chk("call_pc", 32'(prog_ctr), 200);
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        chk("ret_pc", 32'(prog_ctr), 11);
        call_en = 1'b1; target = 12'd200;
        tick();
        chk("call2_pc", 32'(prog_ctr), 200);
        ret_en = 1'b1; target = 12'd300;
        tick();
        clear_ctl();
        chk("ret_wins", 32'(prog_ctr), 12);
        chk("no_err", 32'(stk_err), 0);
        // Four calls fill the stack; the fifth overflows.
        call_en = 1'b1;
        target = 12'd200; tick();
        target = 12'd300; tick();
        target = 12'd400; tick();
        target = 12'd500; tick();
        chk("nest4_pc", 32'(prog_ctr), 500);
        chk("nest4_err", 32'(stk_err), 0);
        target = 12'd600; tick();
        call_en = 1'b0;
        chk("ovf_pc", 32'(prog_ctr), 501);
        chk("ovf_err", 32'(stk_err), 1);
        ret_en = 1'b1;
        tick(); chk("pop1", 32'(prog_ctr), 401);
        tick(); chk("pop2", 32'(prog_ctr), 301);
        tick(); chk("pop3", 32'(prog_ctr), 201);
        tick(); chk("pop4", 32'(prog_ctr), 13);
        tick(); chk("udf_pc", 32'(prog_ctr), 14);
        ret_en = 1'b0;
        chk("udf_err", 32'(stk_err), 1);
`else
        call_en = 1'b1; target = 12'd300;
        tick();
        call_en = 1'b0;
        chk("nostk_call", 32'(prog_ctr), 300);
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        chk("nostk_ret", 32'(prog_ctr), 301);
        chk("nostk_err", 32'(stk_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program-sequencing block for the X9 core: owns the program counter, the req/done run handshake, the registered ALU flags (zero, parity, shift/carry) and a hardware return-address stack. Generalises the fetch path with conditional branches, call/return and a programmable halt address. Sits between the control decoder and jump LUT on one side and the instruction ROM on the other.

## Interface
- D, 12, program-counter width
- HALT_ADDR, 128, PC value that ends a run
- STK_DEPTH, 4, return-stack entries (power of 2, ≥2)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  1  start request (level)
- stall  in  1  hold PC and stack this cycle
- reljump_en  in  1  relative jump request
- absjump_en  in  1  absolute jump request
- call_en  in  1  call: push return address, jump to target
- ret_en  in  1  return: pop stack into PC
- cond_sel  in  2  branch condition: 00 always, 01 zeroQ, 10 pariQ, 11 sc_in
- target  in  D  absolute/call target (from jump LUT)
- offset  in  D  two's-complement relative offset
- zero, pari  in  1  ALU flags
- flag_en  in  1  capture zero/pari
- sc_o  in  1  ALU shift/carry out
- sc_clr, sc_en  in  1  shift/carry clear / load
- prog_ctr  out  D  current PC
- zeroQ, pariQ, sc_in  out  1  registered flags
- busy  out  1  state RUN
- done  out  1  state DONE
- stk_err  out  1  sticky stack overflow/underflow

## Operation
- FSM IDLE → RUN → DONE. IDLE: PC=0; req=1 → RUN. RUN: PC advances each non-stalled cycle; when prog_ctr==HALT_ADDR → DONE (PC frozen). DONE: held while req=1; req=0 → IDLE, PC←0.
- In RUN, not stalled, one PC action per cycle, priority: ret_en > call_en > absjump_en > reljump_en > PC+1.
- cond = selected flag (cond_sel 00 → 1). Taken only if cond=1; untaken → PC+1. ret/call ignore cond_sel.
- rel: PC ← PC + offset, modulo 2^D. abs: PC ← target. PC+1 wraps 2^D−1 → 0.
- call: push PC+1 (mod 2^D), PC ← target. Stack full: no push, PC+1, stk_err←1.
- ret: PC ← top, pop. Stack empty: PC+1, stk_err←1.
- stall=1 or state≠RUN: PC, stack, jump/call/ret ignored. Flags still update.
- Flags: flag_en → zeroQ/pariQ ← zero/pari. sc: sc_clr wins over sc_en; else hold.
- stk_err clears only on reset or IDLE→RUN. Stack emptied on IDLE→RUN.

## Timing
- Reset (reset=0 at edge): state IDLE, prog_ctr=0, zeroQ=pariQ=sc_in=0, stack empty, stk_err=0, busy=done=0. Reset wins over every other input, mid-run included.
- req sampled high in IDLE → busy=1 next cycle with prog_ctr=0.
- All PC/stack effects visible one cycle after the sampling edge; flags likewise one-cycle latency.
- done rises the cycle after prog_ctr==HALT_ADDR is sampled in RUN; falls the cycle after req=0 sampled.
- All outputs registered or decoded from state only; no input-to-output combinational path.

## Configuration
- SEQ_CALL_STACK_EN defined: return stack, call/ret, stk_err as above.
- Undefined: no stack storage; call_en acts as unconditional absolute jump to target; ret_en ignored (PC+1); stk_err tied 0; STK_DEPTH unused.

## Structure
- Package seq_pkg: state enum (IDLE, RUN, DONE), cond_sel encoding enum, default HALT_ADDR constant.
- Sub-module ret_stack (parametrised D, STK_DEPTH: push/pop/clear, full/empty, top), instantiated only under SEQ_CALL_STACK_EN.

## Test plan
- Reset mid-run at PC=37 → next cycle prog_ctr=0, IDLE, busy=0, flags 0; req=1 → RUN from PC=0, increments to 128, done=1, PC holds 128 until req=0.
- PC=20, reljump_en, offset=−5 (0xFFB), cond_sel=01, zeroQ=1 → PC=15; same with zeroQ=0 → PC=21.
- PC=10, call_en target=200 → PC=200; ret_en → PC=11; call+ret same cycle → ret wins.
- STK_DEPTH=4: five nested calls → fifth not taken (PC+1), stk_err=1; pop to empty, extra ret → PC+1, stk_err stays 1.
- stall=1 with absjump_en target=50 at PC=8 → PC stays 8; sc_clr and sc_en both high with sc_o=1 → sc_in=0.
- Macro undefined: call_en target=300 → PC=300, ret_en → PC=301, stk_err=0.
